// File: rtl/serial_accumulator.sv
// Bit-serial accumulator: adds an operand into acc one bit per slow_clk rising edge.
// slow_clk is treated purely as data: it is synchronized into clk_in and edge-detected.
module serial_accumulator #(
    parameter int WIDTH = 8
) (
    input  logic             clk_in,
    input  logic             reset_n,
    input  logic             slow_clk,
    input  logic             start,
    input  logic             clear,
    input  logic [WIDTH-1:0] operand,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] acc,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state;
    logic            sync_1, sync_2, sync_prev;
    logic            step;
    logic [WIDTH-1:0] a_reg, b_reg;
    logic            carry;
    logic [CW-1:0]   cnt;
    logic            sum_bit, carry_nxt;
    logic            last_step;

    // Two-flop synchronizer plus previous-value flop for rising-edge detection
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            sync_1    <= 1'b0;
            sync_2    <= 1'b0;
            sync_prev <= 1'b0;
        end else begin
            sync_1    <= slow_clk;
            sync_2    <= sync_1;
            sync_prev <= sync_2;
        end
    end

    assign step      = sync_2 & ~sync_prev;
    assign sum_bit   = a_reg[0] ^ b_reg[0] ^ carry;
    assign carry_nxt = (a_reg[0] & b_reg[0]) | (a_reg[0] & carry) | (b_reg[0] & carry);
    assign last_step = (cnt == CW'(WIDTH - 1));

    // Control FSM and datapath; acc only changes on clear or on completion
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            acc      <= '0;
            overflow <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            a_reg    <= '0;
            b_reg    <= '0;
            carry    <= 1'b0;
            cnt      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                    if (clear) begin
                        acc      <= '0;
                        overflow <= 1'b0;
                    end else if (start) begin
                        b_reg <= operand;
                        a_reg <= acc;
                        carry <= 1'b0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (step) begin
                        a_reg <= {sum_bit, a_reg[WIDTH-1:1]};
                        b_reg <= b_reg >> 1;
                        carry <= carry_nxt;
                        cnt   <= cnt + 1'b1;
                        if (last_step) begin
                            acc      <= {sum_bit, a_reg[WIDTH-1:1]};
                            overflow <= carry_nxt;
                            done     <= 1'b1;
                            state    <= DONE;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
